// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: byte-wide memory read port plus the decode-stage issue port.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface inst_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_rdy;
    logic [7:0]  mem_data;
    logic        stall;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [15:0] inst;
    logic [7:0]  data;
    logic        en;
    logic [15:0] pc;

    modport master (
        output mem_addr, mem_rd, inst, data, en, pc,
        input  mem_rdy, mem_data, stall, pc_load, pc_target
    );

    modport slave (
        input  mem_addr, mem_rd, inst, data, en, pc,
        output mem_rdy, mem_data, stall, pc_load, pc_target
    );
endinterface

// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles a 16-bit word plus an optional operand byte
// and holds it for the decode stage until it is accepted.
//   state      | meaning
//   FETCH_HI   | read opcode high byte
//   FETCH_LO   | read opcode low byte, decide if an operand byte follows
//   FETCH_DATA | read trailing operand byte
//   ISSUE      | present inst/data to decode, wait for stall to drop
module inst_fetch (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master bus
);

    typedef enum logic [1:0] {
        FETCH_HI   = 2'd0,
        FETCH_LO   = 2'd1,
        FETCH_DATA = 2'd2,
        ISSUE      = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic [7:0]  data_q, data_d;
    logic        has_operand;

    // One-arg instruction whose operand comes from the data stream.
    assign has_operand = (inst_q[15:14] == 2'b10) && (inst_q[10:9] == 2'b01);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        data_d  = data_q;
        case (state_q)
            FETCH_HI: begin
                if (bus.mem_rdy) begin
                    inst_d[15:8] = bus.mem_data;
                    data_d       = 8'h00;
                    pc_d         = pc_q + 16'd1;
                    state_d      = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (bus.mem_rdy) begin
                    inst_d[7:0] = bus.mem_data;
                    pc_d        = pc_q + 16'd1;
                    state_d     = has_operand ? FETCH_DATA : ISSUE;
                end
            end
            FETCH_DATA: begin
                if (bus.mem_rdy) begin
                    data_d  = bus.mem_data;
                    pc_d    = pc_q + 16'd1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.stall) begin
                    state_d = FETCH_HI;
                    if (bus.pc_load) begin
                        pc_d = bus.pc_target;
                    end
                end
            end
            default: state_d = FETCH_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_HI;
            pc_q    <= 16'h0000;
            inst_q  <= 16'h0000;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
        end
    end

    assign bus.mem_addr = pc_q;
    assign bus.pc       = pc_q;
    assign bus.mem_rd   = (state_q != ISSUE);
    assign bus.en       = (state_q == ISSUE);
    assign bus.inst     = inst_q;
    assign bus.data     = data_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences,
// then random traffic checked against an instruction-level reference model.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if bus ();
    inst_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [0:65535];
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] start;
        logic [7:0]  b0, b1, b2;
        logic [15:0] e_inst;
        logic [7:0]  e_data;
        logic [15:0] e_pc;
        int          e_cyc;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction length from the opcode high byte alone.
    function automatic int ilen(input logic [15:0] a);
        logic [7:0] h;
        h = mem[a];
        return (h[7:6] == 2'b10 && h[2:1] == 2'b01) ? 3 : 2;
    endfunction

    task automatic drive_idle();
        bus.mem_rdy   = 1'b0;
        bus.mem_data  = 8'h00;
        bus.stall     = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_target = 16'h0000;
    endtask

    // Returns at a negedge with the DUT in FETCH_HI at pc 0.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        bus.stall   = 1'b1;
        bus.pc_load = 1'b1;
        bus.mem_rdy = 1'b1;
        @(negedge clk);
        chk("rst_en", bus.en, 1'b0);
        chk("rst_mem_rd", bus.mem_rd, 1'b1);
        chk("rst_addr", bus.mem_addr, 16'h0000);
        chk("rst_inst", bus.inst, 16'h0000);
        chk("rst_data", bus.data, 8'h00);
        drive_idle();
        rst_n = 1'b1;
    endtask

    // Memory responder with no wait states; counts cycles starting at 1 in FETCH_HI.
    task automatic wait_en(output int cyc);
        int n;
        n = 1;
        while (!bus.en && n < 20) begin
            bus.mem_rdy  = 1'b1;
            bus.mem_data = mem[bus.mem_addr];
            @(negedge clk);
            n++;
        end
        bus.mem_rdy = 1'b0;
        cyc = n;
    endtask

    task automatic start_at(input logic [15:0] s);
        int c;
        do_reset();
        if (s != 16'h0000) begin
            mem[0] = 8'h00;
            mem[1] = 8'h00;
            wait_en(c);
            bus.stall     = 1'b0;
            bus.pc_load   = 1'b1;
            bus.pc_target = s;
            @(negedge clk);
            bus.pc_load = 1'b0;
            chk("branch_addr", bus.mem_addr, s);
        end
    endtask

    task automatic put3(input logic [15:0] s, input logic [7:0] b0, b1, b2);
        logic [15:0] a;
        a = s;
        mem[a] = b0;
        a = a + 16'd1;
        mem[a] = b1;
        a = a + 16'd1;
        mem[a] = b2;
    endtask

    initial begin
        int          cyc;
        logic [15:0] a, addr;
        int          acc, len;
        bit          exp_en;
        logic [7:0]  ed;

        drive_idle();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        vt[0] = '{16'h0000, 8'h80, 8'h05, 8'h00, 16'h8005, 8'h00, 16'h0002, 3};
        vt[1] = '{16'h0000, 8'h82, 8'h00, 8'h7F, 16'h8200, 8'h7F, 16'h0003, 4};
        vt[2] = '{16'hFFFF, 8'h88, 8'h01, 8'h00, 16'h8801, 8'h00, 16'h0001, 3};
        vt[3] = '{16'hFFFE, 8'h82, 8'h00, 8'h55, 16'h8200, 8'h55, 16'h0001, 4};
        vt[4] = '{16'h1000, 8'hC2, 8'h00, 8'h33, 16'hC200, 8'h00, 16'h1002, 3};
        vt[5] = '{16'h1000, 8'h86, 8'hAA, 8'h33, 16'h86AA, 8'h00, 16'h1002, 3};

        for (int i = 0; i < 6; i++) begin
            start_at(vt[i].start);
            put3(vt[i].start, vt[i].b0, vt[i].b1, vt[i].b2);
            wait_en(cyc);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].e_cyc);
            chk($sformatf("v%0d_inst", i), bus.inst, vt[i].e_inst);
            chk($sformatf("v%0d_data", i), bus.data, vt[i].e_data);
            chk($sformatf("v%0d_pc", i), bus.pc, vt[i].e_pc);
            chk($sformatf("v%0d_mem_rd", i), bus.mem_rd, 1'b0);
        end

        // Three wait states in FETCH_LO delay issue by exactly three cycles.
        start_at(16'h0000);
        put3(16'h0000, 8'h80, 8'h05, 8'h00);
        bus.mem_rdy  = 1'b1;
        bus.mem_data = 8'h80;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            bus.mem_rdy  = 1'b0;
            bus.mem_data = 8'($urandom);
            @(negedge clk);
            chk("ws_pc", bus.pc, 16'h0001);
            chk("ws_inst_hi", bus.inst[15:8], 8'h80);
            chk("ws_en", bus.en, 1'b0);
        end
        bus.mem_rdy  = 1'b1;
        bus.mem_data = 8'h05;
        @(negedge clk);
        bus.mem_rdy = 1'b0;
        chk("ws_issue_en", bus.en, 1'b1);
        chk("ws_issue_inst", bus.inst, 16'h8005);
        chk("ws_issue_pc", bus.pc, 16'h0002);

        // Stall holds the issue; pc_load during stall is ignored, honoured on release.
        start_at(16'h0000);
        put3(16'h0000, 8'h80, 8'h05, 8'h00);
        wait_en(cyc);
        for (int k = 0; k < 4; k++) begin
            bus.stall     = 1'b1;
            bus.pc_load   = (k == 1);
            bus.pc_target = 16'hBEEF;
            @(negedge clk);
            chk("stall_en", bus.en, 1'b1);
            chk("stall_inst", bus.inst, 16'h8005);
            chk("stall_pc", bus.pc, 16'h0002);
        end
        bus.stall     = 1'b0;
        bus.pc_load   = 1'b1;
        bus.pc_target = 16'h1234;
        @(negedge clk);
        bus.pc_load = 1'b0;
        chk("release_addr", bus.mem_addr, 16'h1234);
        chk("release_en", bus.en, 1'b0);

        // Reset in the middle of FETCH_DATA.
        start_at(16'h0000);
        put3(16'h0000, 8'h82, 8'h00, 8'h7F);
        for (int k = 0; k < 2; k++) begin
            bus.mem_rdy  = 1'b1;
            bus.mem_data = mem[bus.mem_addr];
            @(negedge clk);
        end
        chk("fd_pc", bus.pc, 16'h0002);
        chk("fd_en", bus.en, 1'b0);
        rst_n        = 1'b0;
        bus.mem_rdy  = 1'b1;
        bus.mem_data = 8'hAA;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rdy = 1'b0;
        chk("fd_rst_pc", bus.pc, 16'h0000);
        chk("fd_rst_inst", bus.inst, 16'h0000);
        chk("fd_rst_data", bus.data, 8'h00);
        chk("fd_rst_en", bus.en, 1'b0);
        chk("fd_rst_mem_rd", bus.mem_rd, 1'b1);

        // Reset while a three-byte instruction is held in issue.
        start_at(16'h0000);
        wait_en(cyc);
        chk("hold_data", bus.data, 8'h7F);
        bus.stall = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        bus.stall = 1'b0;
        chk("hold_rst_data", bus.data, 8'h00);
        chk("hold_rst_inst", bus.inst, 16'h0000);
        chk("hold_rst_en", bus.en, 1'b0);

        // Random traffic against an instruction-level model.
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        do_reset();
        a   = 16'h0000;
        acc = 0;
        for (int t = 0; t < 4000; t++) begin
            len    = ilen(a);
            exp_en = (acc == len);
            addr   = a + 16'(acc);
            chk("r_en", bus.en, exp_en);
            chk("r_mem_rd", bus.mem_rd, !exp_en);
            chk("r_addr", bus.mem_addr, addr);
            chk("r_pc", bus.pc, addr);
            if (exp_en) begin
                ed = (len == 3) ? mem[16'(a + 16'd2)] : 8'h00;
                chk("r_inst", bus.inst, {mem[a], mem[16'(a + 16'd1)]});
                chk("r_data", bus.data, ed);
            end
            rst_n         = ($urandom_range(0, 299) != 0);
            bus.mem_rdy   = ($urandom_range(0, 3) != 0);
            bus.stall     = ($urandom_range(0, 2) == 0);
            bus.pc_load   = $urandom_range(0, 1);
            bus.pc_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                        : 16'($urandom);
            bus.mem_data  = (bus.mem_rdy && !exp_en) ? mem[addr] : 8'($urandom);
            if (!rst_n) begin
                a   = 16'h0000;
                acc = 0;
            end else if (exp_en) begin
                if (!bus.stall) begin
                    a   = bus.pc_load ? bus.pc_target : 16'(a + 16'(len));
                    acc = 0;
                end
            end else if (bus.mem_rdy) begin
                acc++;
            end
            @(negedge clk);
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; ports: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 mem_addr  output  16  byte address of the current fetch, always equal to pc.
REQ-005 mem_rd  output  1  read request, high in every FETCH_* state.
REQ-006 mem_rdy  input  1  memory has mem_data valid; a byte is accepted on an edge where mem_rd and mem_rdy are both 1.
REQ-007 mem_data  input  8  read data byte.
REQ-008 stall  input  1  execute stage not ready; holds the issued instruction.
REQ-009 pc_load  input  1  branch taken; sampled only on the issue-accept edge.
REQ-010 pc_target  input  16  branch destination address.
REQ-011 inst  output  16  assembled instruction word, high byte first.
REQ-012 data  output  8  trailing operand byte; 8'h00 when the instruction has none.
REQ-013 en  output  1  inst/data valid for the decode stage.
REQ-014 pc  output  16  address of the next byte to fetch.

Function
REQ-015 The FSM SHALL have the states FETCH_HI, FETCH_LO, FETCH_DATA and ISSUE, encoded in 2 bits.
REQ-016 In FETCH_HI, on accept: inst[15:8] <= mem_data, data <= 8'h00, pc <= pc+1, next state FETCH_LO.
REQ-017 In FETCH_LO, on accept: inst[7:0] <= mem_data, pc <= pc+1.
REQ-018 From FETCH_LO, next state SHALL be FETCH_DATA when the completed word has bits [15:14]==2'b10 and [10:9]==2'b01 (one-arg, data-sourced operand); otherwise ISSUE.
REQ-019 In FETCH_DATA, on accept: data <= mem_data, pc <= pc+1, next state ISSUE.
REQ-020 In any FETCH_* state with mem_rdy=0, state, pc, inst and data SHALL hold; wait states are unbounded.
REQ-021 In ISSUE: en=1, mem_rd=0, and inst/data SHALL be stable.
REQ-022 In ISSUE with stall=1: hold all state, keep en=1, ignore pc_load.
REQ-023 In ISSUE with stall=0 (issue accept): next state FETCH_HI; pc <= pc_target if pc_load=1, else pc unchanged.
REQ-024 en SHALL be 0 in all states other than ISSUE; en and mem_rd are never high together.
REQ-025 pc arithmetic SHALL be modulo 2^16; 16'hFFFF+1 wraps to 16'h0000, including when the wrap falls inside an instruction.
REQ-026 pc_load, pc_target and stall SHALL be ignored outside ISSUE.
REQ-027 Minimum latency, no wait states: 2-byte instruction, en high on the 3rd cycle after leaving FETCH_HI entry; 3-byte instruction, on the 4th.
REQ-028 mem_data SHALL be sampled only on accept edges; its value at other times has no effect.

Reset
REQ-029 When rst_n=0 on an edge: state <= FETCH_HI, pc <= 16'h0000, inst <= 16'h0000, data <= 8'h00.
REQ-030 Outputs during and after reset: en=0, mem_rd=1 (FETCH_HI), mem_addr=16'h0000.
REQ-031 Reset SHALL take priority over every other input and abort any partial fetch or held issue without side effects.

Verification
REQ-032 Reset, mem_rdy=1, memory 00:80 01:05 -> en=1 on cycle 3 with inst=16'h8005, data=8'h00, pc=16'h0002.
REQ-033 Memory 00:82 01:00 02:7F, mem_rdy=1 -> FETCH_DATA visited; en=1 with inst=16'h8200, data=8'h7F, pc=16'h0003.
REQ-034 mem_rdy low for 3 cycles during FETCH_LO -> pc, inst[15:8] and state held; en asserted exactly 3 cycles later than the no-wait case.
REQ-035 ISSUE held with stall=1 for 4 cycles, with pc_load pulsed during the stall -> en stays 1, inst constant, pc unchanged; on release with pc_load=1 and pc_target=16'h1234 -> next mem_addr=16'h1234.
REQ-036 Start at pc=16'hFFFF via branch, memory FFFF:88 0000:01 -> inst=16'h8801, pc=16'h0001 at issue.
REQ-037 rst_n pulsed low while in FETCH_DATA -> next cycle state FETCH_HI, pc=0, inst=0, data=0, en=0.
